// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with valid/ready output and sticky overflow.
// Optional even-parity bit after each word when SIPO_PARITY_EN is defined.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             sdi_i,
    input  logic             sdi_vld_i,
    input  logic             clr_i,
    input  logic             q_rdy_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_vld_o,
    output logic             ovf_o,
    output logic             par_err_o
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
        , PAR = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_vld_q, q_vld_d;
    logic              ovf_q, ovf_d;
    logic              par_err_q, par_err_d;

    logic [WIDTH-1:0]  sh_shift_s;
    logic [WIDTH-1:0]  word_s;
    logic              done_s;
    logic              perr_s;
    logic              unused_s;

    assign unused_s = ^sh_q;

    // Shift register contents after accepting sdi_i in the configured bit order.
    always_comb begin
        sh_shift_s = sh_q;
        if (MSB_FIRST != 0) begin
            sh_shift_s = {sh_q[WIDTH-2:0], sdi_i};
        end else begin
            sh_shift_s = {sdi_i, sh_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: bit assembly, word completion and output handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        q_d       = q_q;
        q_vld_d   = q_vld_q;
        ovf_d     = ovf_q;
        par_err_d = par_err_q;
        done_s    = 1'b0;
        word_s    = sh_shift_s;
        perr_s    = 1'b0;

        if (clr_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            sh_d      = '0;
            ovf_d     = 1'b0;
            par_err_d = 1'b0;
        end else if (sdi_vld_i) begin
            case (state_q)
                IDLE: begin
                    sh_d    = sh_shift_s;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sh_d = sh_shift_s;
                    if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_EN
                        cnt_d   = CW'(WIDTH);
                        state_d = PAR;
`else
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_s  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                // The parity bit is not shifted in; the data word is already complete.
                PAR: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_s  = 1'b1;
                    word_s  = sh_q;
                    perr_s  = (^sh_q) ^ sdi_i;
                end
`endif
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (done_s && (!q_vld_q || q_rdy_i)) begin
            q_d       = word_s;
            q_vld_d   = 1'b1;
            par_err_d = perr_s;
        end else if (done_s) begin
            ovf_d = 1'b1;
        end else if (q_vld_q && q_rdy_i) begin
            q_vld_d = 1'b0;
        end else begin
            q_vld_d = q_vld_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            q_q       <= '0;
            q_vld_q   <= 1'b0;
            ovf_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            q_q       <= q_d;
            q_vld_q   <= q_vld_d;
            ovf_q     <= ovf_d;
            par_err_q <= par_err_d;
        end
    end

    assign q_o       = q_q;
    assign q_vld_o   = q_vld_q;
    assign ovf_o     = ovf_q;
    assign par_err_o = par_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (MSB-first and LSB-first instances).
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst_;
    logic       sdi;
    logic       sdi_vld;
    logic       clr;
    logic       q_rdy;
    logic [3:0] q_m, q_l;
    logic       q_vld_m, q_vld_l;
    logic       ovf_m, ovf_l;
    logic       perr_m, perr_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_(rst_), .sdi_i(sdi), .sdi_vld_i(sdi_vld), .clr_i(clr),
        .q_rdy_i(q_rdy), .q_o(q_m), .q_vld_o(q_vld_m), .ovf_o(ovf_m), .par_err_o(perr_m)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_(rst_), .sdi_i(sdi), .sdi_vld_i(sdi_vld), .clr_i(clr),
        .q_rdy_i(q_rdy), .q_o(q_l), .q_vld_o(q_vld_l), .ovf_o(ovf_l), .par_err_o(perr_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sdi     = b;
        sdi_vld = 1'b1;
        tick();
        sdi_vld = 1'b0;
    endtask

    // Sends w[3] first; q_rdy switches to rdy_last just before the completion edge.
    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
            if (i == 0) q_rdy = rdy_last;
`endif
            send_bit(w[i]);
        end
`ifdef SIPO_PARITY_EN
        q_rdy = rdy_last;
        send_bit(^w);
`endif
    endtask

    initial begin
        rst_ = 1'b0; sdi = 1'b0; sdi_vld = 1'b0; clr = 1'b0; q_rdy = 1'b0;
        tick(); tick();
        check_eq("rst_q",     {28'd0, q_m}, 32'h0);
        check_eq("rst_q_vld", {31'd0, q_vld_m}, 32'h0);
        check_eq("rst_ovf",   {31'd0, ovf_m}, 32'h0);
        check_eq("rst_perr",  {31'd0, perr_m}, 32'h0);
        rst_ = 1'b1;
        tick();

        // 1,0,1,1 -> 1011 MSB-first, 1101 LSB-first
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check_eq("pre_done_vld", {31'd0, q_vld_m}, 32'h0);
        send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        check_eq("pre_par_vld", {31'd0, q_vld_m}, 32'h0);
        send_bit(1'b1);
`endif
        check_eq("msb_q",     {28'd0, q_m}, 32'hB);
        check_eq("msb_vld",   {31'd0, q_vld_m}, 32'h1);
        check_eq("lsb_q",     {28'd0, q_l}, 32'hD);
        check_eq("lsb_vld",   {31'd0, q_vld_l}, 32'h1);

        // Async reset mid-word, with a held word pending
        send_bit(1'b1); send_bit(1'b0);
        check_eq("held_vld", {31'd0, q_vld_m}, 32'h1);
        #2 rst_ = 1'b0;
        #1;
        check_eq("async_vld", {31'd0, q_vld_m}, 32'h0);
        check_eq("async_q",   {28'd0, q_m}, 32'h0);
        #1 rst_ = 1'b1;
        q_rdy = 1'b1;
        send_word(4'b0110, 1'b1);
        check_eq("post_rst_q",   {28'd0, q_m}, 32'h6);
        check_eq("post_rst_lsb", {28'd0, q_l}, 32'h6);
        check_eq("post_rst_vld", {31'd0, q_vld_m}, 32'h1);
        tick();
        check_eq("consume_vld", {31'd0, q_vld_m}, 32'h0);
        check_eq("consume_q",   {28'd0, q_m}, 32'h6);

        // Backpressure: second word dropped
        q_rdy = 1'b0;
        send_word(4'b0011, 1'b0);
        check_eq("bp_q1",     {28'd0, q_m}, 32'h3);
        check_eq("bp_q1_lsb", {28'd0, q_l}, 32'hC);
        check_eq("bp_ovf0",   {31'd0, ovf_m}, 32'h0);
        send_word(4'b0101, 1'b0);
        check_eq("bp_q2",     {28'd0, q_m}, 32'h3);
        check_eq("bp_vld2",   {31'd0, q_vld_m}, 32'h1);
        check_eq("bp_ovf",    {31'd0, ovf_m}, 32'h1);
        check_eq("bp_ovf_l",  {31'd0, ovf_l}, 32'h1);
        q_rdy = 1'b1;
        tick();
        check_eq("bp_drain_vld", {31'd0, q_vld_m}, 32'h0);
        check_eq("bp_ovf_hold",  {31'd0, ovf_m}, 32'h1);

        // Simultaneous consume and completion
        q_rdy = 1'b0;
        send_word(4'b0101, 1'b0);
        check_eq("sim_q1", {28'd0, q_m}, 32'h5);
        send_word(4'b1110, 1'b1);
        check_eq("sim_q2",   {28'd0, q_m}, 32'hE);
        check_eq("sim_vld",  {31'd0, q_vld_m}, 32'h1);
        check_eq("sim_ovf",  {31'd0, ovf_m}, 32'h1);
        tick();
        check_eq("sim_drain", {31'd0, q_vld_m}, 32'h0);

        // Abort a partial word, then bits with gaps
        send_bit(1'b1); send_bit(1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("clr_ovf", {31'd0, ovf_m}, 32'h0);
        q_rdy = 1'b0;
        send_bit(1'b0); tick(); tick(); tick();
        send_bit(1'b1); tick(); tick(); tick();
        send_bit(1'b0); tick(); tick(); tick();
        send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        tick(); tick(); tick();
        send_bit(1'b0);
`endif
        check_eq("gap_q",     {28'd0, q_m}, 32'h5);
        check_eq("gap_q_lsb", {28'd0, q_l}, 32'hA);
        check_eq("gap_vld",   {31'd0, q_vld_m}, 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("clr_keeps_vld", {31'd0, q_vld_m}, 32'h1);
        check_eq("clr_keeps_q",   {28'd0, q_m}, 32'h5);
        q_rdy = 1'b1;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        check_eq("clr_handshake", {31'd0, q_vld_m}, 32'h0);

`ifdef SIPO_PARITY_EN
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check_eq("par_ok_q",   {28'd0, q_m}, 32'hB);
        check_eq("par_ok_err", {31'd0, perr_m}, 32'h0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check_eq("par_bad_q",   {28'd0, q_m}, 32'hB);
        check_eq("par_bad_err", {31'd0, perr_m}, 32'h1);
`else
        send_word(4'b1000, 1'b1);
        check_eq("nopar_q",   {28'd0, q_m}, 32'h8);
        check_eq("nopar_err", {31'd0, perr_m}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer that collects bits from a one-bit serial stream and assembles them into WIDTH-bit words. It sits directly upstream of the 4-bit parallel-in/parallel-out holding register and produces the parallel word that register captures. A valid/ready handshake on the output lets assembly continue while a finished word waits to be consumed, and a sticky overflow flag reports dropped words.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: the first serial bit lands in q[WIDTH-1]; 0: the first serial bit lands in q[0].
- clk  in  1  clock; all state changes on the rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- sdi  in  1  serial data bit, sampled only when sdi_vld=1.
- sdi_vld  in  1  bit strobe; one bit is accepted per clock edge with sdi_vld=1.
- clr  in  1  synchronous abort; discards the partial word and clears ovf and par_err.
- q  out  WIDTH  assembled word; stable while q_vld=1.
- q_vld  out  1  q holds an unconsumed word.
- q_rdy  in  1  downstream accepts q on an edge where q_vld=1 and q_rdy=1.
- ovf  out  1  sticky; a completed word was dropped.
- par_err  out  1  parity flag for the word in q; constant 0 when parity is compiled out.

## Operation
- Internal state: shift register sh[WIDTH-1:0] and bit counter cnt, counting 0..WIDTH-1, or 0..WIDTH when parity is compiled in.
- State machine:
  - IDLE (cnt=0): the first accepted bit moves to SHIFT.
  - SHIFT (0<cnt<WIDTH): each accepted bit increments cnt.
  - When parity is compiled in, PAR (cnt=WIDTH) waits for the parity bit.
  - Completion returns to IDLE with cnt=0.
- Shift rules:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], sdi}.
  - MSB_FIRST=0: sh <= {sdi, sh[WIDTH-1:1]}.
- Completion: the edge that accepts the last bit of a word (bit WIDTH, or the parity bit when compiled in) is the completion edge.
  - If q_vld=0, or q_rdy=1 on that edge: q <= assembled word (including the bit just accepted) and q_vld <= 1.
  - If q_vld=1 and q_rdy=0: the new word is dropped, q and q_vld are unchanged, and ovf <= 1.
- Consume: on an edge with q_vld=1 and q_rdy=1 and no completion, q_vld <= 0 and q holds its last value.
- A simultaneous consume and completion loads the new word and keeps q_vld=1, giving back-to-back words with no bubble.
- clr has priority over sdi_vld:
  - cnt <= 0 and sh <= 0; ovf <= 0 and par_err <= 0.
  - q and q_vld are unaffected, and a handshake on the same edge still completes.
- An edge with sdi_vld=0 leaves sh and cnt unchanged. Gaps between bits of any length are legal.

## Timing
- Reset values: q=0, q_vld=0, ovf=0, par_err=0; internally sh=0, cnt=0 (IDLE).
- Reset asserted mid-word discards the partial word and any held word immediately, without waiting for a clock edge.
- Latency: q_vld rises in the cycle after the completion edge, so q is valid one clock after the last bit is sampled.
- Throughput: one bit per clock. With q_rdy held at 1, q_vld pulses for one cycle every WIDTH (or WIDTH+1) accepted bits.
- ovf stays 1 until clr or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SIPO_PARITY_EN defined:
  - After the WIDTH data bits, one extra accepted bit is an even-parity bit.
  - On the completion edge, par_err <= (^data) ^ parity_bit, loaded together with q.
  - par_err is meaningful only while q_vld=1 and is cleared by clr.
  - A dropped word does not update par_err.
- SIPO_PARITY_EN undefined:
  - A word completes on the WIDTH-th bit.
  - par_err is tied to 0 and the PAR state does not exist.

## Test plan
- Reset: hold rst_=0 → q=4'h0, q_vld=0, ovf=0, par_err=0. Assert rst_ asynchronously after 2 bits → cnt returns to 0, and the next 4 bits form a clean word.
- WIDTH=4, MSB_FIRST=1, sdi=1,0,1,1 on consecutive edges, q_rdy=1 → q=4'b1011 and q_vld=1 one cycle after the 4th bit. With MSB_FIRST=0, the same stream gives q=4'b1101.
- Backpressure: q_rdy=0, send 8 bits (0011 then 0101) → q stays 4'b0011, ovf=1. Raise q_rdy → q_vld drops the next cycle and ovf stays 1 until clr.
- Simultaneous: q_vld=1, q_rdy=1 on the completion edge of a second word 4'b1110 → q=4'b1110 and q_vld stays 1 with no gap.
- Abort and gaps:
  - Send 1,1, then clr → the partial word is discarded.
  - Then send 0,1,0,1 with 3 idle cycles between bits → q=4'b0101.
- SIPO_PARITY_EN: send 1,0,1,1 then parity 1 → q=4'b1011, par_err=0. Send parity 0 instead → par_err=1.
